// File: rtl/link_fault_injector.sv
// Inline fault injector for one credit-based NoC link: the datapath is combinational and forwards flits.
// Every N packets it hangs, drops or corrupts one packet; N is drawn from an LFSR within a run-time range.
module link_fault_injector #(
  parameter int          FLIT_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [15:0]           cfg_interval_min_i,
  input  logic [15:0]           cfg_interval_max_i,
  input  logic [15:0]           cfg_cycles_min_i,
  input  logic [15:0]           cfg_cycles_max_i,
  input  logic [FLIT_WIDTH-1:0] cfg_mask_i,
  input  logic                  tx_i,
  input  logic [FLIT_WIDTH-1:0] data_i,
  input  logic                  eop_i,
  output logic                  credit_o,
  output logic                  rx_o,
  output logic [FLIT_WIDTH-1:0] data_o,
  output logic                  eop_o,
  input  logic                  credit_i,
  output logic                  active_o,
  output logic [15:0]           attack_count_o
);

  localparam logic [1:0] MODE_HANG    = 2'd1;
  localparam logic [1:0] MODE_DROP    = 2'd2;
  localparam logic [1:0] MODE_CORRUPT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_HANG,
    S_DROP,
    S_CORRUPT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [15:0] next_pkt_q;
  logic [15:0] hang_cnt_q;
  logic        attacked_q;
  logic        attack_start;
  logic        xfer;
  logic        eop_xfer;

  // min + (rnd mod span) in 17-bit arithmetic; a degenerate range yields min.
  function automatic logic [15:0] draw(input logic [15:0] lo, input logic [15:0] hi,
                                       input logic [15:0] rnd);
    logic [16:0] span;
    logic [15:0] res;
    span = {1'b0, hi} - {1'b0, lo} + 17'd1;
    if (hi <= lo) res = lo;
    else          res = 16'({1'b0, lo} + ({1'b0, rnd} % span));
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    rx_o         = tx_i;
    data_o       = data_i;
    eop_o        = eop_i;
    credit_o     = credit_i;
    attack_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        attack_start = tx_i && credit_i && cfg_en_i && (cfg_mode_i != 2'd0) && (next_pkt_q == 16'd0);
        if (attack_start) begin
          // The first flit is already subject to drop/corrupt; hang lets the header through.
          case (cfg_mode_i)
            MODE_DROP: begin
              rx_o     = 1'b0;
              eop_o    = 1'b0;
              credit_o = 1'b1;
              if (!eop_i) state_d = S_DROP;
            end
            MODE_CORRUPT: begin
              data_o = data_i ^ cfg_mask_i;
              if (!eop_i) state_d = S_CORRUPT;
            end
            MODE_HANG: begin
              if (!eop_i) state_d = S_HANG;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (tx_i && credit_i && !eop_i) begin
          state_d = S_PASS;
        end
      end
      S_PASS: begin
        if (tx_i && credit_i && eop_i) state_d = S_IDLE;
      end
      S_HANG: begin
        rx_o     = 1'b0;
        credit_o = 1'b0;
        if (hang_cnt_q == 16'd0) state_d = S_PASS;
      end
      S_DROP: begin
        rx_o     = 1'b0;
        eop_o    = 1'b0;
        credit_o = 1'b1;
        if (tx_i && eop_i) state_d = S_IDLE;
      end
      S_CORRUPT: begin
        data_o = data_i ^ cfg_mask_i;
        if (tx_i && credit_i && eop_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xfer     = tx_i && credit_o;
  assign eop_xfer = xfer && eop_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_SEED;
      next_pkt_q     <= 16'd0;
      hang_cnt_q     <= 16'd0;
      attacked_q     <= 1'b0;
      active_o       <= 1'b0;
      attack_count_o <= 16'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

      // Attacked packets (including single-flit ones) re-arm the interval at their last flit.
      if (eop_xfer) begin
        if (attack_start || attacked_q)
          next_pkt_q <= draw(cfg_interval_min_i, cfg_interval_max_i, lfsr_q);
        else if (next_pkt_q != 16'd0)
          next_pkt_q <= next_pkt_q - 16'd1;
      end

      if (eop_xfer)          attacked_q <= 1'b0;
      else if (attack_start) attacked_q <= 1'b1;

      if (attack_start && cfg_mode_i == MODE_HANG)
        hang_cnt_q <= draw(cfg_cycles_min_i, cfg_cycles_max_i, lfsr_q);
      else if (state_q == S_HANG && hang_cnt_q != 16'd0)
        hang_cnt_q <= hang_cnt_q - 16'd1;

      active_o <= attack_start || (state_d == S_HANG) || (state_d == S_DROP) || (state_d == S_CORRUPT);

      if (attack_start && attack_count_o != 16'hFFFF)
        attack_count_o <= attack_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_link_fault_injector.sv
// Bench for link_fault_injector: packet-level reference model checked every cycle, plus directed scenarios.
module tb_link_fault_injector;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_mode_i;
  logic [15:0] cfg_interval_min_i, cfg_interval_max_i;
  logic [15:0] cfg_cycles_min_i, cfg_cycles_max_i;
  logic [31:0] cfg_mask_i;
  logic        tx_i, eop_i, credit_i;
  logic [31:0] data_i;
  logic        credit_o, rx_o, eop_o, active_o;
  logic [31:0] data_o;
  logic [15:0] attack_count_o;

  always #5 clk = ~clk;

  link_fault_injector #(.FLIT_WIDTH(32), .LFSR_SEED(16'hACE1)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_mode_i(cfg_mode_i),
    .cfg_interval_min_i(cfg_interval_min_i), .cfg_interval_max_i(cfg_interval_max_i),
    .cfg_cycles_min_i(cfg_cycles_min_i), .cfg_cycles_max_i(cfg_cycles_max_i),
    .cfg_mask_i(cfg_mask_i), .tx_i(tx_i), .data_i(data_i), .eop_i(eop_i),
    .credit_o(credit_o), .rx_o(rx_o), .data_o(data_o), .eop_o(eop_o),
    .credit_i(credit_i), .active_o(active_o), .attack_count_o(attack_count_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view of the link
  int          m_next_pkt;
  bit   [15:0] m_lfsr;
  bit          m_in_pkt;
  int          m_attack;     // mode attacking the current packet, 0 if none
  int          m_hang_left;  // remaining hang cycles after this one, -1 when not hanging
  bit          m_active;
  int          m_count;
  logic [31:0] dq[$];        // flits delivered downstream
  bit          saw_active;
  bit          rand_cr = 1'b0;

  function automatic int draw(input int lo, input int hi, input int r);
    if (hi <= lo) return lo;
    return lo + (r % (hi - lo + 1));
  endfunction

  always @(negedge clk) begin : cmp
    logic        e_rx, e_eop, e_cr, start, hang, xfer;
    logic [31:0] e_data;
    int          am;
    if (rst_i) begin
      chk("rst_rx", rx_o, tx_i);
      chk("rst_credit", credit_o, credit_i);
      chk("rst_active", active_o, 0);
      chk("rst_count", attack_count_o, 0);
      m_next_pkt = 0; m_lfsr = 16'hACE1; m_in_pkt = 0; m_attack = 0;
      m_hang_left = -1; m_active = 0; m_count = 0;
    end else begin
      hang  = (m_hang_left >= 0);
      start = !m_in_pkt && tx_i && credit_i && cfg_en_i && (cfg_mode_i != 2'd0) && (m_next_pkt == 0);
      am    = m_in_pkt ? m_attack : (start ? int'(cfg_mode_i) : 0);
      e_rx = tx_i; e_data = data_i; e_eop = eop_i; e_cr = credit_i;
      if (hang) begin
        e_rx = 0; e_cr = 0;
      end else if (am == 2) begin
        e_rx = 0; e_eop = 0; e_cr = 1;
      end else if (am == 3) begin
        e_data = data_i ^ cfg_mask_i;
      end
      chk("rx", rx_o, e_rx);
      chk("credit", credit_o, e_cr);
      if (e_rx) begin
        chk("data", data_o, e_data);
        chk("eop", eop_o, e_eop);
      end
      chk("active", active_o, m_active);
      chk("count", attack_count_o, m_count);
      if (rx_o && credit_i) dq.push_back(data_o);
      if (active_o) saw_active = 1;

      xfer = tx_i && e_cr;
      if (start) begin
        m_count  = (m_count < 65535) ? m_count + 1 : 65535;
        m_attack = cfg_mode_i;
      end
      if (hang) m_hang_left = (m_hang_left == 0) ? -1 : m_hang_left - 1;
      else if (start && cfg_mode_i == 2'd1 && !eop_i)
        m_hang_left = draw(cfg_cycles_min_i, cfg_cycles_max_i, m_lfsr);
      if (xfer && eop_i) begin
        if (m_attack != 0) m_next_pkt = draw(cfg_interval_min_i, cfg_interval_max_i, m_lfsr);
        else if (m_next_pkt > 0) m_next_pkt--;
        m_in_pkt = 0; m_attack = 0;
      end else if (xfer) begin
        m_in_pkt = 1;
      end
      m_active = start || (m_hang_left >= 0) || (m_in_pkt && (m_attack == 2 || m_attack == 3));
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Drive one flit and hold it until the upstream side sees a credit.
  task automatic send_flit(input logic [31:0] d, input logic e, output int blocked);
    bit got;
    tx_i = 1; data_i = d; eop_i = e; blocked = 0;
    while (1) begin
      @(negedge clk);
      got = credit_o;
      if (!got) blocked++;
      @(posedge clk); #1;
      if (rand_cr) credit_i = 1'($urandom_range(0, 1));
      if (got) break;
      if (blocked > 300) begin
        chk("flit_timeout", blocked, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    tx_i = 0; eop_i = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int id, input int len, output int blocked_total);
    int b;
    blocked_total = 0;
    for (int i = 0; i < len; i++) begin
      send_flit({16'(id), 16'(i)}, i == len - 1, b);
      blocked_total += b;
    end
    tx_i = 0; eop_i = 0;
  endtask

  task automatic do_reset();
    tx_i = 0; eop_i = 0; rst_i = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst_i = 0;
    dq.delete();
    saw_active = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sq[$];
    int b, b1, mism;
    rst_i = 1; cfg_en_i = 0; cfg_mode_i = 0; cfg_mask_i = 0;
    cfg_interval_min_i = 0; cfg_interval_max_i = 0;
    cfg_cycles_min_i = 0; cfg_cycles_max_i = 0;
    tx_i = 0; data_i = 0; eop_i = 0; credit_i = 1;
    repeat (3) begin @(posedge clk); #1; end
    rst_i = 0;
    chk("reset_count_lit", attack_count_o, 16'd0);
    chk("reset_active_lit", active_o, 0);

    // Bypass mode: stream must be untouched, with random downstream credit
    cfg_en_i = 1; cfg_mode_i = 0; rand_cr = 1; dq.delete(); saw_active = 0;
    for (int p = 0; p < 100; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        sq.push_back({16'(p), 16'(i)});
        send_flit({16'(p), 16'(i)}, i == len - 1, b);
      end
      tx_i = 0;
    end
    rand_cr = 0; credit_i = 1; idle(2);
    chk("bypass_len", dq.size(), sq.size());
    mism = 0;
    for (int i = 0; i < sq.size() && i < dq.size(); i++) if (dq[i] !== sq[i]) mism++;
    chk("bypass_data_mismatch", mism, 0);
    chk("bypass_count", attack_count_o, 0);
    chk("bypass_saw_active", saw_active, 0);

    // Hang 5 cycles on a 4-flit packet: header passes, 6 blocked cycles
    do_reset();
    cfg_mode_i = 1; cfg_cycles_min_i = 5; cfg_cycles_max_i = 5;
    send_flit(32'h0001_0000, 0, b);
    chk("hang_header_blocked", b, 0);
    chk("hang_header_fwd", dq.size(), 1);
    send_flit(32'h0001_0001, 0, b1);
    chk("hang_blocked_cycles", b1, 6);
    send_flit(32'h0001_0002, 0, b);
    send_flit(32'h0001_0003, 1, b1);
    chk("hang_tail_blocked", b + b1, 0);
    tx_i = 0; idle(1);
    chk("hang_delivered", dq.size(), 4);
    chk("hang_count", attack_count_o, 1);
    // Zero-length hang still blocks one cycle; single-flit hang blocks nothing
    cfg_cycles_min_i = 0; cfg_cycles_max_i = 0;
    send_flit(32'h0002_0000, 0, b);
    send_flit(32'h0002_0001, 0, b1);
    chk("hang0_blocked", b1, 1);
    send_flit(32'h0002_0002, 1, b);
    tx_i = 0;
    send_flit(32'h0003_0000, 1, b);
    tx_i = 0; idle(1);
    chk("hang_single_blocked", b, 0);
    chk("hang_single_count", attack_count_o, 3);

    // Drop every third packet: 1, 4, 7 vanish, credit forced high for them
    do_reset();
    cfg_mode_i = 2; cfg_interval_min_i = 2; cfg_interval_max_i = 2;
    b1 = 0;
    for (int p = 1; p <= 7; p++) begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0 && (p == 1 || p == 4 || p == 7)) credit_i = 0;
        send_flit({16'(p), 16'(i)}, i == 2, b);
        b1 += b;
      end
      tx_i = 0; credit_i = 1;
    end
    idle(1);
    chk("drop_blocked", b1, 0);
    chk("drop_delivered", dq.size(), 12);
    begin
      int exp_ids[4] = '{2, 3, 5, 6};
      mism = 0;
      for (int i = 0; i < 12 && i < dq.size(); i++) if (dq[i][31:16] != 16'(exp_ids[i / 3])) mism++;
      chk("drop_ids", mism, 0);
    end
    chk("drop_count", attack_count_o, 3);

    // Corrupt first packet; mode change mid-packet has no effect
    do_reset();
    cfg_mode_i = 3; cfg_mask_i = 32'hFFFF_0000; cfg_interval_min_i = 5; cfg_interval_max_i = 5;
    send_flit(32'h1234_5678, 0, b);
    cfg_mode_i = 0;
    send_flit(32'h1234_5678, 0, b);
    send_flit(32'h1234_5678, 1, b);
    cfg_mode_i = 3;
    for (int i = 0; i < 3; i++) send_flit(32'h1234_5678, i == 2, b);
    tx_i = 0; idle(1);
    chk("corrupt_len", dq.size(), 6);
    for (int i = 0; i < 6 && i < dq.size(); i++)
      chk($sformatf("corrupt_flit%0d", i), dq[i], (i < 3) ? 32'hEDCB_5678 : 32'h1234_5678);
    chk("corrupt_count", attack_count_o, 1);

    // Disable during a drop: packet still dropped, next_pkt keeps counting
    do_reset();
    cfg_mode_i = 2; cfg_interval_min_i = 1; cfg_interval_max_i = 1; cfg_en_i = 1;
    send_flit(32'h000A_0000, 0, b);
    cfg_en_i = 0;
    send_flit(32'h000A_0001, 0, b);
    send_flit(32'h000A_0002, 1, b);
    tx_i = 0;
    chk("en_drop_empty", dq.size(), 0);
    send_pkt(11, 3, b);
    send_pkt(12, 2, b);
    chk("en_off_count", attack_count_o, 1);
    cfg_en_i = 1;
    send_pkt(13, 3, b);
    idle(1);
    chk("en_on_delivered", dq.size(), 5);
    chk("en_on_count", attack_count_o, 2);

    // Reset in the middle of a long hang
    do_reset();
    cfg_mode_i = 1; cfg_interval_min_i = 0; cfg_interval_max_i = 0;
    cfg_cycles_min_i = 1000; cfg_cycles_max_i = 1000;
    send_flit(32'h0020_0000, 0, b);
    tx_i = 1; data_i = 32'h0020_0001; eop_i = 0;
    repeat (10) begin @(posedge clk); #1; end
    chk("hang_long_active", active_o, 1);
    chk("hang_long_credit", credit_o, 0);
    rst_i = 1; #1;
    chk("rst_mid_rx", rx_o, 1);
    chk("rst_mid_active", active_o, 0);
    chk("rst_mid_count", attack_count_o, 0);
    cfg_en_i = 0;
    @(posedge clk); #1;
    rst_i = 0;
    @(negedge clk);
    chk("post_rst_rx", rx_o, 1);
    chk("post_rst_credit", credit_o, 1);
    @(posedge clk); #1;
    tx_i = 0; idle(2);

    // Mixed modes with drawn ranges and random credit, checked by the model
    do_reset();
    cfg_en_i = 1; cfg_interval_min_i = 1; cfg_interval_max_i = 3;
    cfg_cycles_min_i = 2; cfg_cycles_max_i = 6; cfg_mask_i = 32'h0F0F_00FF;
    rand_cr = 1;
    for (int p = 0; p < 45; p++) begin
      cfg_mode_i = 2'(1 + (p / 15));
      send_pkt(100 + p, $urandom_range(1, 5), b);
      if (p % 4 == 0) idle(1);
    end
    rand_cr = 0; credit_i = 1; idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_fault_injector.md
# link_fault_injector

Parametrised successor of the single-mode link hang injector: sits inline on one credit-based NoC link between a router output and the neighbouring router input. It forwards flits transparently. Every N packets (N drawn pseudo-randomly in a configured range) it attacks one packet in a run-time selectable mode: hang, drop or corrupt. Configuration comes from ports rather than files, so the block runs in simulation and on FPGA.

## Interface
- FLIT_WIDTH, 32, data bits per flit
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- cfg_en_i  in  1  attacks allowed when 1
- cfg_mode_i  in  2  0 bypass, 1 hang, 2 drop, 3 corrupt
- cfg_interval_min_i / cfg_interval_max_i  in  16 each  packets between attacks, range
- cfg_cycles_min_i / cfg_cycles_max_i  in  16 each  hang length in cycles, range
- cfg_mask_i  in  FLIT_WIDTH  XOR mask used by corrupt mode
- tx_i  in  1  upstream flit valid
- data_i  in  FLIT_WIDTH  upstream flit
- eop_i  in  1  upstream flit is last of packet
- credit_o  out  1  credit to upstream
- rx_o  out  1  downstream flit valid
- data_o  out  FLIT_WIDTH  downstream flit
- eop_o  out  1  downstream end of packet
- credit_i  in  1  credit from downstream
- active_o  out  1  an attack is in progress (registered)
- attack_count_o  out  16  attacks started, saturating

## Operation
- Transfer is defined as tx_i && credit_o. EOP transfer is a transfer with eop_i=1.
- LFSR: 16-bit Galois, taps 16'hB400, shift every cycle, reset to LFSR_SEED.
- Draw(min,max) = min + (lfsr % (max-min+1)). If max <= min, draw = min. All arithmetic is 17-bit unsigned.
- next_pkt counter (16 b): reset to 0.
  - Decrements on every EOP transfer of a non-attacked packet, saturating at 0.
  - Loads Draw(interval) on the EOP transfer that ends an attacked packet.
- hang_cnt (16 b): loads Draw(cycles) when a hang attack starts. Decrements each cycle in HANG.
- Attack start condition: in IDLE, a transfer occurs with cfg_en_i=1, cfg_mode_i!=0 and next_pkt==0.
- FSM states: IDLE, PASS, HANG, DROP, CORRUPT.
  - IDLE: pass-through. On a transfer:
    - Single-flit packet with no attack: stay in IDLE.
    - Start flit with no attack: go to PASS.
    - Attack start: go to the mode state. An attacked single-flit packet returns to IDLE, and in hang mode no hang occurs.
  - PASS: pass-through. Go to IDLE on EOP transfer.
  - HANG: the header was already forwarded normally. rx_o=0 and credit_o=0.
    - When hang_cnt==0, go to PASS.
    - A hang of 0 cycles lasts exactly 1 blocked cycle.
  - DROP: the first flit is also swallowed. rx_o=0, eop_o=0, credit_o=1 (upstream is drained). Go to IDLE on EOP transfer.
  - CORRUPT: data_o = data_i ^ cfg_mask_i for every flit of the packet, including the first. Go to IDLE on EOP transfer.
- Pass-through means rx_o=tx_i, data_o=data_i, eop_o=eop_i, credit_o=credit_i.
- cfg_mode_i is sampled only at attack start. Mode changes mid-attack have no effect.
- cfg_en_i=0 blocks new attacks only. An ongoing attack completes, and next_pkt keeps counting.
- attack_count_o increments on each attack start and saturates at 16'hFFFF.

## Timing
- Data path is combinational in every state: zero-cycle latency in pass-through.
- Reset (asynchronous, active-high) forces:
  - state=IDLE, so datapath outputs follow the pass-through function during and immediately after reset.
  - active_o=0, attack_count_o=0, next_pkt=0, hang_cnt=0, lfsr=LFSR_SEED.
- Consequence of next_pkt=0 at reset: the first packet after reset with cfg_en_i=1 and cfg_mode_i!=0 is attacked.
- active_o is 1 in the cycle after attack start and remains 1 while state is HANG, DROP or CORRUPT.
- Attack-start decision in IDLE is combinational on tx_i, credit_i and next_pkt in the same cycle.
- Reset asserted mid-attack: the attack is abandoned immediately and the link reverts to pass-through. The downstream packet may be truncated; this is accepted.
- Simultaneous tx_i=1 and credit_i=0 in IDLE: no transfer, no state change.

## Test plan
- Mode 0, 100 random packets of length 1-8 -> output flit stream identical to input, attack_count_o=0, active_o never 1.
- Hang mode, interval 0..0, cycles 5..5, 4-flit packet -> header forwarded in cycle 0. rx_o and credit_o are 0 for 6 cycles. Remaining 3 flits pass. attack_count_o=1.
- Drop mode, interval 2..2, packets of 3 flits -> packets 1, 4 and 7 are absent downstream. Upstream sees credit_o=1 throughout those packets. attack_count_o=3 after 7 packets.
- Corrupt mode, mask 32'hFFFF_0000, first packet data 32'h1234_5678 -> data_o=32'hEDCB_5678 on all flits of packet 1 only; packet 2 is unmodified.
- cfg_en_i deasserted mid-DROP -> current packet still dropped. No further attacks occur while cfg_en_i=0, though next_pkt keeps counting.
- Reset pulse during HANG with hang_cnt=1000 -> next cycle state is IDLE, rx_o follows tx_i, active_o=0, attack_count_o=0.
